// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types and constants for the gate vector sequencer
package gate_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int NUM_VEC = 4;

   // Bit positions of each gate result inside the 6-bit result bus
   localparam int BIT_AND  = 5;
   localparam int BIT_NAND = 4;
   localparam int BIT_NOR  = 3;
   localparam int BIT_XOR  = 2;
   localparam int BIT_XNOR = 1;
   localparam int BIT_NOTA = 0;

endpackage

// File: rtl/gate_seq_ref_model.sv
// rtl/gate_seq_ref_model.sv - combinational expected-value model of the gate stage
module gate_ref_model
   import gate_seq_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [5:0] exp
);

   // Golden gate results for the currently driven a/b pair
   always_comb begin
      exp           = '0;
      exp[BIT_AND]  = a & b;
      exp[BIT_NAND] = ~(a & b);
      exp[BIT_NOR]  = ~(a | b);
      exp[BIT_XOR]  = a ^ b;
      exp[BIT_XNOR] = ~(a ^ b);
      exp[BIT_NOTA] = ~a;
   end

endmodule

// File: rtl/gate_vector_sequencer.sv
// rtl/gate_vector_sequencer.sv - exhaustive 2-input gate stage tester; GATE_SEQ_STOP_ON_FAIL_EN ends the run at the first failing vector
module gate_vector_sequencer
   import gate_seq_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic [5:0] dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] vec;
   logic [1:0] vec_nxt;
   logic [3:0] cnt;
   logic [5:0] exp;
   logic       mismatch;
   logic       stop_hit;
   logic       last_vec;
   logic       start_ok;

   gate_ref_model u_ref (
      .a   (a),
      .b   (b),
      .exp (exp)
   );

   assign mismatch = (dut_out != exp);
   assign vec_nxt  = vec + 2'd1;

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
   assign stop_hit = mismatch;
`else
   assign stop_hit = 1'b0;
`endif

   assign last_vec = (vec == 2'(NUM_VEC - 1)) || stop_hit;

   // A start is only honoured when idle or after the result has been published
   assign start_ok = start && ((state == ST_IDLE) || ((state == ST_DONE) && done));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start_ok) state_nxt = ST_SETTLE;
         ST_SETTLE: if (cnt <= 4'd1) state_nxt = ST_CHECK;
         ST_CHECK:  state_nxt = last_vec ? ST_DONE : ST_SETTLE;
         ST_DONE:   if (start_ok) state_nxt = ST_SETTLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Stimulus, settle counter and result bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec       <= '0;
         a         <= 1'b0;
         b         <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_mask <= '0;
      end else begin
         case (state)
            ST_SETTLE: begin
               if (cnt > 4'd1) cnt <= cnt - 4'd1;
            end
            ST_CHECK: begin
               if (mismatch) begin
                  fail_mask[vec] <= 1'b1;
                  if (err_count != 3'(NUM_VEC)) err_count <= err_count + 3'd1;
               end
               if (last_vec) begin
                  a   <= 1'b0;
                  b   <= 1'b0;
                  cnt <= '0;
               end else begin
                  vec <= vec_nxt;
                  a   <= vec_nxt[1];
                  b   <= vec_nxt[0];
                  cnt <= 4'(SETTLE);
               end
            end
            default: begin
               if ((state == ST_DONE) && !done) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                  pass <= (err_count == 3'd0);
               end else if (start_ok) begin
                  vec       <= '0;
                  a         <= 1'b0;
                  b         <= 1'b0;
                  cnt       <= 4'(SETTLE);
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_mask <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/gate_vector_sequencer.md
GATE_VECTOR_SEQUENCER -- requirements
Module: gate_vector_sequencer

Interface
REQ-001 SHALL have parameter: SETTLE, 2, cycles a vector is held before its check (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to run the full vector set.
REQ-005 SHALL have port: a  output  1  stimulus bit A to the two-input gate stage.
REQ-006 SHALL have port: b  output  1  stimulus bit B to the two-input gate stage.
REQ-007 SHALL have port: dut_out  input  6  gate-stage results, [5..0] = {AND, NAND, NOR, XOR, XNOR, NOT A}.
REQ-008 SHALL have port: busy  output  1  high from the cycle after an accepted start until done rises.
REQ-009 SHALL have port: done  output  1  high once the run completes; held until the next accepted start or rst.
REQ-010 SHALL have port: pass  output  1  high with done when err_count == 0.
REQ-011 SHALL have port: err_count  output  3  number of failing vectors, 0..4.
REQ-012 SHALL have port: fail_mask  output  4  bit i set when vector i failed.

Function
REQ-013 SHALL use states IDLE, SETTLE, CHECK and DONE.
REQ-014 Vector i (0..3) SHALL drive a = i[1] and b = i[0], in order 00, 01, 10, 11.
REQ-015 In IDLE or DONE, start = 1 SHALL: load vector 0, clear err_count/fail_mask/pass/done, load the settle counter with SETTLE, and enter SETTLE.
REQ-016 SETTLE SHALL hold a/b stable and decrement the counter, entering CHECK on the cycle the counter reaches 1.
REQ-017 CHECK SHALL compare dut_out against the expected value {a&b, ~(a&b), ~(a|b), a^b, ~(a^b), ~a}; any mismatch SHALL set fail_mask[i] and increment err_count.
REQ-018 After CHECK of vector 3, the FSM SHALL enter DONE; otherwise it SHALL advance to the next vector, reload the counter and enter SETTLE.
REQ-019 Each vector SHALL take SETTLE+1 cycles; done SHALL rise 4*(SETTLE+1)+1 cycles after the start edge.
REQ-020 start while busy SHALL be ignored.
REQ-021 a and b SHALL change only on entry to SETTLE; in IDLE and DONE they SHALL hold 0.
REQ-022 err_count SHALL saturate at 4 and never wrap.

Reset
REQ-023 rst SHALL force state IDLE and a=b=busy=done=pass=0, err_count=0, fail_mask=0, counter=0, immediately and regardless of clk.
REQ-024 rst asserted mid-run SHALL abort the run with no partial result retained; a new start is required after release.

Configuration
REQ-025 With GATE_SEQ_STOP_ON_FAIL_EN defined, the first failing CHECK SHALL go directly to DONE (pass=0), skipping the remaining vectors.
REQ-026 Without GATE_SEQ_STOP_ON_FAIL_EN, all four vectors SHALL always be run.

Structure
REQ-027 Package gate_seq_pkg SHALL hold the state enum, NUM_VEC=4, and the 6-bit output bit-position constants.
REQ-028 The expected-value function SHALL be a combinational sub-module, gate_ref_model (inputs a, b; output exp[5:0]), instantiated once.

Verification
REQ-029 Correct gate stage, SETTLE=2, single start -> done at cycle 13, pass=1, err_count=0, fail_mask=0000.
REQ-030 NAND bit (dut_out[4]) stuck 0 -> err_count=3, fail_mask=0111, pass=0; with GATE_SEQ_STOP_ON_FAIL_EN -> err_count=1, fail_mask=0001, done at cycle 4.
REQ-031 start pulsed again during SETTLE of vector 1 -> ignored; done still at cycle 13.
REQ-032 rst asserted during CHECK of vector 2 -> all outputs 0 asynchronously, state IDLE; a subsequent start runs a clean full pass.
REQ-033 Second start while in DONE, after a failing run -> results cleared in the next cycle, vector 00 driven, then pass=1 if the gate stage is now correct.
REQ-034 SETTLE=1 -> a/b change every 2 cycles; done at cycle 9.
